// File: rtl/scm_fifo_ctrl.sv
// scm_fifo_ctrl
// -------------
// FIFO controller for an external 1R1W register file with a one-cycle
// registered read. Entries are written straight into the register file.
// Reads are issued ahead of time into a two-entry output buffer (head + skid),
// so the pop side can sustain one transfer per cycle despite the read latency.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready. valid never depends on ready. Once out_valid is raised it
// stays high, with out_data held, until the entry is popped (or the block is
// flushed/reset).
//
// Ports
//   clk, rst           : clock and synchronous active-high reset
//   flush              : synchronous clear of all contents
//   in_valid/in_ready/in_data     : push side
//   out_valid/out_ready/out_data  : pop side (out_data = head of buffer)
//   mem_we/mem_waddr/mem_wdata    : register-file write port
//   mem_re/mem_raddr/mem_rdata    : register-file read port; mem_rdata is
//                                   valid in the cycle after mem_re
//   count              : entries held (register file + in-flight + buffer)
module scm_fifo_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic       push;
  logic       pop;
  logic       capture;
  logic [2:0] occ_after_pop;

  assign in_ready  = (mem_count_q < DEPTH_C) && !flush && !rst;
  assign push      = in_valid && in_ready;
  assign out_valid = (buf_cnt_q != 2'd0) && !rst;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_q;

  // Buffer slots that stay claimed after this cycle's pop: held entries plus
  // the one still arriving. A new read is only issued if it has a slot.
  assign occ_after_pop = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign mem_re        = (mem_count_q != '0) && (occ_after_pop < 3'd2) && !flush && !rst;

  // Read data from a read issued before a flush/reset is dropped here.
  assign capture = inflight_q && !flush && !rst;

  assign mem_we    = push;
  assign mem_waddr = wptr_q;
  assign mem_wdata = in_data;
  assign mem_raddr = rptr_q;

  assign count = rst ? '0
               : mem_count_q + (ADDR_WIDTH + 1)'(inflight_q) + (ADDR_WIDTH + 1)'(buf_cnt_q);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    mem_count_d = mem_count_q;
    buf_cnt_d   = buf_cnt_q;
    inflight_d  = mem_re;
    head_d      = head_q;
    skid_d      = skid_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push)   wptr_d = wptr_q + 1'b1;
    if (mem_re) rptr_d = rptr_q + 1'b1;
    mem_count_d = mem_count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(mem_re);

    // Captured data always lands behind whatever remains after the pop.
    case ({capture, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) head_d = mem_rdata;
        else                   skid_d = mem_rdata;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d    = skid_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          head_d = mem_rdata;
        end else begin
          head_d = skid_q;
          skid_d = mem_rdata;
        end
      end
      default: ;
    endcase

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      mem_count_d = '0;
      buf_cnt_d   = '0;
      inflight_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_count_q <= '0;
      buf_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_count_q <= mem_count_d;
      buf_cnt_q   <= buf_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  // Payload registers carry no reset; they are only observed while valid.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Testbench for scm_fifo_ctrl with a behavioural register file and a
// queue-based reference: the FIFO must deliver exactly the accepted words,
// in order, and count must equal accepted minus delivered.
module tb_scm_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, flush;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  scm_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .count(count)
  );

  // Behavioural 1R1W register file with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  // ---------------- scoreboard ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples at the falling edge, i.e. the values that the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_count", count, 0);
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("count", count, exp_q.size());
      if (exp_q.size() == 0) chk("out_valid_empty", out_valid, 0);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_data);
      end
      if (flush) begin
        chk("flush_in_ready", in_ready, 0);
        chk("flush_mem_re", mem_re, 0);
      end else begin
        if (exp_q.size() < DEPTH) chk("in_ready_room", in_ready, 1);
        if (exp_q.size() == DEPTH + 2) chk("in_ready_full", in_ready, 0);
      end
      chk("mem_we", mem_we, in_valid && in_ready);
      if (mem_we) chk("mem_wdata", mem_wdata, in_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_empty actual=0x%0h expected=none", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      stall_data = out_data;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (count != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_done", count, 0);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, k, stalls, pushed, n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // Latency: push into empty block, visible three cycles later.
    in_valid = 1'b1; in_data = 16'h00A5;
    step();
    in_valid = 1'b0;
    chk("lat_c1_count", count, 1);
    chk("lat_c1_valid", out_valid, 0);
    chk("lat_c1_re", mem_re, 1);
    step();
    chk("lat_c2_valid", out_valid, 0);
    chk("lat_c2_count", count, 1);
    step();
    chk("lat_c3_valid", out_valid, 1);
    chk("lat_c3_data", out_data, 16'h00A5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_after_pop", count, 0);

    // Fill with the pop side stalled: DEPTH + 2 words fit.
    acc = 0; k = 1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (k <= 8);
      in_data  = 16'h0010 + 16'(k);
      if (in_valid && in_ready) begin
        acc++;
        k++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("fill_accepts", acc, 6);
    chk("fill_count", count, 6);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_out_data", out_data, 16'h0011);
    drain();

    // Streaming: one push and one pop every cycle after priming.
    stalls = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 16'($urandom);
      if (i >= 10) begin
        if (!out_valid) stalls++;
        if (!in_ready) stalls++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("stream_stalls", stalls, 0);
    drain();

    // Random backpressure over 200 words.
    pushed = 0; n = 0;
    while (pushed < 200 && n < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 1) != 0);
      if (in_valid && in_ready) pushed++;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("bp_pushed", pushed, 200);
    drain();
    chk("bp_queue_empty", exp_q.size(), 0);

    // Flush while a read is in flight and the buffer holds an entry.
    in_valid = 1'b1;
    in_data = 16'h0101; step();
    in_data = 16'h0202; step();
    in_data = 16'h0303;
    chk("flush_pre_re", mem_re, 1);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_pre_count", count, 3);
    chk("flush_hold_ready", in_ready, 0);
    chk("flush_hold_re", mem_re, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_post_valid", out_valid, 0);
    chk("flush_post_count", count, 0);
    in_valid = 1'b1; in_data = 16'h003C;
    step();
    in_valid = 1'b0;
    chk("flush_c1_valid", out_valid, 0);
    step();
    chk("flush_c2_valid", out_valid, 0);
    step();
    chk("flush_c3_valid", out_valid, 1);
    chk("flush_c3_data", out_data, 16'h003C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("flush_end_count", count, 0);

    // Reset mid-stream with five entries held.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("rstm_pre_count", count, 5);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    #1;
    chk("rstm_in_ready", in_ready, 0);
    chk("rstm_mem_we", mem_we, 0);
    chk("rstm_count", count, 0);
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rstm_rel_ready", in_ready, 1);
    chk("rstm_rel_count", count, 0);
    chk("rstm_rel_valid", out_valid, 0);
    step();
    step();
    chk("rstm_late_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound for the whole run.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
